// File: rtl/cp0_unit.sv
// CP0 status/cause/EPC block: exception and interrupt entry, eret, and mtc0/mfc0 access.
// Latency: req, cp0_out and epc_out are combinational; register updates land on the next posedge.
// Backpressure: none. A req suppresses eret and mtc0 in the same cycle; the suppressed write is dropped. Optional CP0_BD_EN enables delay-slot BD/EPC capture.
module cp0_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] cp0_out,
    output logic [31:0] epc_out,
    output logic        req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic        bd_cap;
    logic [31:0] epc_cap;

    assign int_req = sr_ie_q & ~sr_exl_q & (|(hw_int & sr_im_q));
    assign exc_req = ~sr_exl_q & (exc_code_in != 5'd0);
    assign req     = int_req | exc_req;

    assign sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    assign cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};

`ifdef CP0_BD_EN
    // A delay-slot victim restarts at its branch so the branch re-executes.
    assign bd_cap  = bd_in;
    assign epc_cap = bd_in ? (vpc - 32'd4) : vpc;
`else
    assign bd_cap  = 1'b0;
    assign epc_cap = vpc;
`endif

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? 5'd0 : exc_code_in;
            cause_bd_d  = bd_cap;
            epc_d       = epc_cap;
        end else if (exl_clr) begin
            sr_exl_d = 1'b0;
        end else if (en) begin
            if (cp0_addr == ADDR_SR) begin
                sr_im_d  = cp0_in[15:10];
                sr_exl_d = cp0_in[1];
                sr_ie_d  = cp0_in[0];
            end else if (cp0_addr == ADDR_EPC) begin
                epc_d = cp0_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        cp0_out = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_out = sr_word;
            ADDR_CAUSE: cp0_out = cause_word;
            ADDR_EPC:   cp0_out = epc_q;
            default:    cp0_out = 32'd0;
        endcase
    end

    assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios followed by random traffic against a word-level model.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] cp0_out;
    logic [31:0] epc_out;
    logic        req;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .exl_clr(exl_clr), .cp0_out(cp0_out), .epc_out(epc_out), .req(req)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state held as architectural 32-bit words.
    logic [31:0] m_sr = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc = 32'd0;
    logic        m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic m_int();
        logic [5:0] im;
        im = m_sr[15:10];
        return m_sr[0] && !m_sr[1] && ((hw_int & im) != 6'd0);
    endfunction

    function automatic logic m_exc();
        return !m_sr[1] && (exc_code_in != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd12) return m_sr;
        if (a == 5'd13) return m_cause;
        if (a == 5'd14) return m_epc;
        return 32'd0;
    endfunction

    task automatic idle();
        reset = 1'b0; en = 1'b0; cp0_addr = 5'd0; cp0_in = 32'd0; vpc = 32'd0;
        bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; exl_clr = 1'b0;
    endtask

    // One clock: compare combinational outputs to the model, then advance both.
    task automatic cyc(input string tag);
        logic [31:0] nsr, nc, ne;
        logic ir, er;
        #3;
        if (m_valid) begin
            chk({tag, ".req"}, {31'd0, req}, {31'd0, m_int() | m_exc()});
            chk({tag, ".cp0_out"}, cp0_out, m_read(cp0_addr));
            chk({tag, ".epc_out"}, epc_out, m_epc);
        end
        nsr = m_sr; nc = m_cause; ne = m_epc;
        ir = m_int(); er = m_exc();
        if (reset) begin
            nsr = 32'd0; nc = 32'd0; ne = 32'd0;
        end else begin
            nc[15:10] = hw_int;
            if (ir || er) begin
                nsr[1] = 1'b1;
                nc[6:2] = ir ? 5'd0 : exc_code_in;
`ifdef CP0_BD_EN
                nc[31] = bd_in;
                ne = bd_in ? vpc - 32'd4 : vpc;
`else
                ne = vpc;
`endif
            end else if (exl_clr) begin
                nsr[1] = 1'b0;
            end else if (en) begin
                if (cp0_addr == 5'd12) nsr = cp0_in & 32'h0000_FC03;
                else if (cp0_addr == 5'd14) ne = cp0_in;
            end
        end
        @(posedge clk);
        if (reset) m_valid = 1'b1;
        m_sr = nsr; m_cause = nc; m_epc = ne;
        #1;
    endtask

    logic [31:0] rd;

    initial begin
        idle();
        reset = 1'b1;
        cyc("reset");
        idle();
        #3;
        chk("post_reset.req", {31'd0, req}, 32'd0);
        chk("post_reset.sr", cp0_out, 32'd0);
        chk("post_reset.epc", epc_out, 32'd0);

        // Synchronous exception entry
        exc_code_in = 5'd4; vpc = 32'h3010;
        #1 chk("exc.req_same_cycle", {31'd0, req}, 32'd1);
        cyc("exc");
        idle(); cp0_addr = 5'd13;
        #1 rd = cp0_out; chk("exc.exccode", {27'd0, rd[6:2]}, 32'd4);
        cp0_addr = 5'd12;
        #1 rd = cp0_out; chk("exc.exl", {31'd0, rd[1]}, 32'd1);
        chk("exc.epc", epc_out, 32'h3010);
        exl_clr = 1'b1; cyc("eret1");

        // Interrupt entry
        idle(); en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_0401; cyc("mtc0_sr");
        idle(); hw_int = 6'b000001; vpc = 32'h3020;
        #1 chk("int.req", {31'd0, req}, 32'd1);
        cyc("int");
        cp0_addr = 5'd13;
        #1 chk("int.masked_by_exl", {31'd0, req}, 32'd0);
        rd = cp0_out;
        chk("int.ip", {26'd0, rd[15:10]}, 32'd1);
        chk("int.exccode", {27'd0, rd[6:2]}, 32'd0);
        chk("int.epc", epc_out, 32'h3020);
        cyc("int_hold");

        // eret then re-take the pending interrupt
        idle(); hw_int = 6'b000001; exl_clr = 1'b1; cyc("eret2");
        exl_clr = 1'b0; cp0_addr = 5'd12;
        #1 rd = cp0_out; chk("ret.exl", {31'd0, rd[1]}, 32'd0);
        chk("ret.req_again", {31'd0, req}, 32'd1);
        cyc("ret_int");
        idle(); exl_clr = 1'b1; cyc("eret3");

        // Delay-slot victim
        idle(); exc_code_in = 5'd12; vpc = 32'h3104; bd_in = 1'b1; cyc("bd");
        idle(); cp0_addr = 5'd13;
        #1 rd = cp0_out;
`ifdef CP0_BD_EN
        chk("bd.epc", epc_out, 32'h3100);
        chk("bd.bit31", {31'd0, rd[31]}, 32'd1);
`else
        chk("bd.epc", epc_out, 32'h3104);
        chk("bd.bit31", {31'd0, rd[31]}, 32'd0);
`endif
        exl_clr = 1'b1; cyc("eret4");

        // mtc0 EPC colliding with an exception is dropped
        idle(); en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'hDEAD_0000;
        exc_code_in = 5'd10; vpc = 32'h3040; cyc("collide");
        idle();
        #1 chk("collide.epc", epc_out, 32'h3040);
        exl_clr = 1'b1; cyc("eret5");

        // Reset during an active request
        idle(); exc_code_in = 5'd5; vpc = 32'h3050;
        #1 chk("rst.req_before", {31'd0, req}, 32'd1);
        reset = 1'b1; cyc("rst_req");
        idle();
        #1 chk("rst.req", {31'd0, req}, 32'd0);
        cp0_addr = 5'd12; #1 chk("rst.sr", cp0_out, 32'd0);
        cp0_addr = 5'd13; #1 chk("rst.cause", cp0_out, 32'd0);
        chk("rst.epc", epc_out, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            reset       = ($urandom_range(0, 49) == 0);
            en          = ($urandom_range(0, 2) == 0);
            exl_clr     = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0: cp0_addr = 5'd12;
                1: cp0_addr = 5'd13;
                2: cp0_addr = 5'd14;
                default: cp0_addr = 5'($urandom_range(0, 31));
            endcase
            cp0_in      = $urandom;
            vpc         = $urandom;
            bd_in       = 1'($urandom_range(0, 1));
            exc_code_in = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw_int      = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
